// File: rtl/multicycle_controller_if.sv
// Shared memory port between the multicycle controller and the memory subsystem.
// The controller is the master; memory answers with mem_ack in the same cycle.
interface multicycle_controller_if;
  // mem_req is raised by the master and held until a cycle in which mem_ack is
  // high. That cycle completes the transfer. mem_we and mem_addr_sel are
  // meaningful only while mem_req is high.
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit MiniMIPS core (FETCH/DECODE/EXEC/MEM/WB).
// Optional macro ILLEGAL_TRAP_EN: illegal op/func traps to FAULT instead of acting as a NOP.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  multicycle_controller_if.master mem,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        imm_sign,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] START  = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [2:0] state, next_state;
  logic [3:0] op_q;
  logic [2:0] func_q;
  logic [7:0] wait_cnt;
  logic       illegal;
  logic       taken;
  logic       unused_instr;

  // Only op and func are consumed here; the register fields feed the datapath.
  assign unused_instr = ^instr[11:3];
  assign state_dbg    = state;

  always_comb begin
    next_state       = state;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    alu_src_b        = 1'b0;
    alu_op           = ALU_ADD;
    imm_sign         = 1'b0;
    reg_dst          = 1'b0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    fault            = 1'b0;
    illegal          = 1'b0;
    taken            = 1'b0;
    case (state)
      START: next_state = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          next_state = FAULT;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        case (op_q)
          4'd0: begin
            if (func_q <= 3'd4) begin
              alu_op     = func_q;
              next_state = WB;
            end else begin
              illegal = 1'b1;
            end
          end
          4'd1: begin alu_src_b = 1'b1; imm_sign = 1'b1; alu_op = ALU_ADD; next_state = WB; end
          4'd2: begin alu_src_b = 1'b1; alu_op = ALU_AND; next_state = WB; end
          4'd3: begin alu_src_b = 1'b1; alu_op = ALU_OR;  next_state = WB; end
          4'd4: begin alu_src_b = 1'b1; imm_sign = 1'b1; alu_op = ALU_SLT; next_state = WB; end
          4'd5, 4'd6: begin
            alu_src_b  = 1'b1;
            imm_sign   = 1'b1;
            alu_op     = ALU_ADD;
            next_state = MEM;
          end
          4'd7, 4'd8: begin
            alu_op     = ALU_SUB;
            imm_sign   = 1'b1;
            taken      = (op_q == 4'd7) ? alu_zero : !alu_zero;
            pc_write   = taken;
            pc_src     = taken;
            next_state = FETCH;
          end
          default: illegal = 1'b1;
        endcase
        // Illegal encodings leave every ALU/strobe output at its idle value.
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          next_state = FAULT;
`else
          next_state = FETCH;
`endif
        end
      end
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (op_q == 4'd6);
        if (mem.mem_ack) begin
          next_state = (op_q == 4'd6) ? FETCH : WB;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          next_state = FAULT;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == 4'd0);
        mem_to_reg = (op_q == 4'd5);
        next_state = FETCH;
      end
      FAULT: fault = 1'b1;
      default: next_state = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= START;
      op_q     <= 4'd0;
      func_q   <= 3'd0;
      wait_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_q   <= instr[15:12];
        func_q <= instr[2:0];
      end
      // The count restarts on every entry to a request state, so each request gets its own budget.
      if ((next_state != state) && ((next_state == FETCH) || (next_state == MEM))) begin
        wait_cnt <= 8'd0;
      end else if (((state == FETCH) || (state == MEM)) && !mem.mem_ack && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instructions run with immediate acks,
// plus hand-written sequences for delayed acks, timeout, illegal ops and reset.
module tb_multicycle_controller;

  localparam logic [15:0] B_REQ  = 16'h8000;
  localparam logic [15:0] B_WE   = 16'h4000;
  localparam logic [15:0] B_SEL  = 16'h2000;
  localparam logic [15:0] B_IRW  = 16'h1000;
  localparam logic [15:0] B_PCW  = 16'h0800;
  localparam logic [15:0] B_PCS  = 16'h0400;
  localparam logic [15:0] B_SRCB = 16'h0200;
  localparam logic [15:0] B_IMMS = 16'h0020;
  localparam logic [15:0] B_RDST = 16'h0010;
  localparam logic [15:0] B_REGW = 16'h0008;
  localparam logic [15:0] B_M2R  = 16'h0004;
  localparam logic [15:0] B_FLT  = 16'h0002;
  localparam logic [15:0] FETCH_OK = B_REQ | B_IRW | B_PCW;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        zero;
    logic [1:0]  kind;     // 0: ALU op then WB, 1: lw, 2: sw, 3: back to FETCH after EXEC
    logic [15:0] exec_exp;
    logic [15:0] wb_exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        alu_zero;
  logic        ir_write, pc_write, pc_src, alu_src_b, imm_sign;
  logic        reg_dst, reg_write, mem_to_reg, fault;
  logic [2:0]  alu_op;
  logic [2:0]  state_dbg;
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vecs[14];

  multicycle_controller_if mif ();

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_sign(imm_sign), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] aop(input logic [2:0] a);
    return {7'd0, a, 6'd0};
  endfunction

  function automatic logic [15:0] actual();
    return {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, pc_write, pc_src,
            alu_src_b, alu_op, imm_sign, reg_dst, reg_write, mem_to_reg, fault, 1'b0};
  endfunction

  task automatic check(input string nm);
    logic [15:0] got, e;
    got = actual();
    e   = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state %0d)", nm, got, e, state_dbg);
    end
  endtask

  // Drive ack for one cycle just after the edge, sample at the falling edge.
  task automatic cyc(input logic ack, input logic [15:0] e, input string nm);
    mif.mem_ack = ack;
    exp_q.push_back(e);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    mif.mem_ack = 1'b1;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    check("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 16'h0000, "start");
  endtask

  task automatic run_vec(input vec_t v);
    instr    = v.instr;
    alu_zero = v.zero;
    cyc(1'b1, FETCH_OK, {v.name, "/fetch"});
    cyc(1'b1, 16'h0000, {v.name, "/decode"});
    cyc(1'b1, v.exec_exp, {v.name, "/exec"});
    case (v.kind)
      2'd0: cyc(1'b1, v.wb_exp, {v.name, "/wb"});
      2'd1: begin
        cyc(1'b1, B_REQ | B_SEL, {v.name, "/mem"});
        cyc(1'b1, v.wb_exp, {v.name, "/wb"});
      end
      2'd2: cyc(1'b1, B_REQ | B_WE | B_SEL, {v.name, "/mem"});
      default: ;
    endcase
  endtask

  initial begin
    vecs[0]  = '{"add",     16'h04C8, 1'b0, 2'd0, aop(3'd0), B_REGW | B_RDST};
    vecs[1]  = '{"sub",     16'h04C9, 1'b0, 2'd0, aop(3'd1), B_REGW | B_RDST};
    vecs[2]  = '{"and",     16'h04CA, 1'b1, 2'd0, aop(3'd2), B_REGW | B_RDST};
    vecs[3]  = '{"or",      16'h04CB, 1'b0, 2'd0, aop(3'd3), B_REGW | B_RDST};
    vecs[4]  = '{"slt",     16'h04CC, 1'b0, 2'd0, aop(3'd4), B_REGW | B_RDST};
    vecs[5]  = '{"addi",    16'h103F, 1'b0, 2'd0, B_SRCB | B_IMMS | aop(3'd0), B_REGW};
    vecs[6]  = '{"andi",    16'h203F, 1'b0, 2'd0, B_SRCB | aop(3'd2), B_REGW};
    vecs[7]  = '{"ori",     16'h3005, 1'b0, 2'd0, B_SRCB | aop(3'd3), B_REGW};
    vecs[8]  = '{"slti",    16'h4001, 1'b0, 2'd0, B_SRCB | B_IMMS | aop(3'd4), B_REGW};
    vecs[9]  = '{"lw",      16'h5044, 1'b0, 2'd1, B_SRCB | B_IMMS, B_REGW | B_M2R};
    vecs[10] = '{"sw",      16'h6044, 1'b0, 2'd2, B_SRCB | B_IMMS, 16'h0000};
    vecs[11] = '{"beq_tk",  16'h7002, 1'b1, 2'd3, B_PCW | B_PCS | B_IMMS | aop(3'd1), 16'h0000};
    vecs[12] = '{"beq_nt",  16'h7002, 1'b0, 2'd3, B_IMMS | aop(3'd1), 16'h0000};
    vecs[13] = '{"bne_tk",  16'h8002, 1'b0, 2'd3, B_PCW | B_PCS | B_IMMS | aop(3'd1), 16'h0000};

    reset       = 1'b1;
    instr       = 16'h04C8;
    alu_zero    = 1'b0;
    mif.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    run_vec('{"bne_nt", 16'h8002, 1'b1, 2'd3, B_IMMS | aop(3'd1), 16'h0000});

    // lw with mem_ack arriving in the fourth MEM cycle
    instr = 16'h5044;
    cyc(1'b1, FETCH_OK, "lwd/fetch");
    cyc(1'b0, 16'h0000, "lwd/decode");
    cyc(1'b0, B_SRCB | B_IMMS, "lwd/exec");
    for (int i = 0; i < 3; i++) cyc(1'b0, B_REQ | B_SEL, "lwd/mem_wait");
    cyc(1'b1, B_REQ | B_SEL, "lwd/mem_ack");
    cyc(1'b0, B_REGW | B_M2R, "lwd/wb");

    // ack in the same cycle the wait count reaches MEM_TIMEOUT still completes
    instr = 16'h04C8;
    for (int i = 0; i < 15; i++) cyc(1'b0, B_REQ, "late/fetch_wait");
    cyc(1'b1, FETCH_OK, "late/fetch_ack");
    cyc(1'b1, 16'h0000, "late/decode");
    cyc(1'b1, 16'h0000, "late/exec");
    cyc(1'b1, B_REGW | B_RDST, "late/wb");

    // illegal op 0xF
    instr = 16'hF000;
    cyc(1'b1, FETCH_OK, "ill/fetch");
    cyc(1'b1, 16'h0000, "ill/decode");
    cyc(1'b1, 16'h0000, "ill/exec");
`ifdef ILLEGAL_TRAP_EN
    cyc(1'b1, B_FLT, "ill/fault");
    cyc(1'b1, B_FLT, "ill/fault_hold");
    do_reset();
`else
    instr = 16'h04C8;
    cyc(1'b1, FETCH_OK, "ill/nop_fetch");
    cyc(1'b1, 16'h0000, "ill/nop_decode");
    cyc(1'b1, 16'h0000, "ill/nop_exec");
    cyc(1'b1, B_REGW | B_RDST, "ill/nop_wb");
`endif

    // reset in the middle of a pending fetch drops mem_req without a clock edge
    cyc(1'b0, B_REQ, "rst_mid/fetch");
    cyc(1'b0, B_REQ, "rst_mid/fetch");
    reset = 1'b1;
    #1;
    exp_q.push_back(16'h0000);
    check("rst_mid/async");
    do_reset();

    // fetch timeout: MEM_TIMEOUT+1 cycles without ack, then sticky fault
    for (int i = 0; i < 16; i++) cyc(1'b0, B_REQ, "tmo/fetch_wait");
    cyc(1'b0, B_FLT, "tmo/fault");
    cyc(1'b1, B_FLT, "tmo/fault_sticky");
    cyc(1'b1, B_FLT, "tmo/fault_sticky");
    do_reset();
    cyc(1'b1, FETCH_OK, "post_rst/fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
